// File: rtl/ws_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws_sched_pkg
// Purpose  : Shared types and constants for the weight-stationary memory
//            scheduler: FSM state encoding, transfer op encoding and the
//            beat-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package ws_sched_pkg;

    // Beat counter width; bursts are limited to 1..63 beats.
    localparam int BEAT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_LOAD   = 1'b0,
        OP_UNLOAD = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/ws_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : ws_rr_picker
// Purpose  : Combinational round-robin priority select. Searches i_req
//            upward from i_rr_ptr, wrapping modulo NUM_CORES, and returns the
//            first requesting index.
// Ports    : i_req    - request vector
//            i_rr_ptr - index with highest priority this round
//            o_valid  - at least one request present
//            o_sel    - selected index (0 when o_valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module ws_rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IW        = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [IW-1:0]        i_rr_ptr,
    output logic                 o_valid,
    output logic [IW-1:0]        o_sel
);

    int w_idx;

    // Walk from the farthest offset down to offset 0 so that the candidate
    // closest to the pointer is the last (winning) assignment.
    always_comb begin
        o_valid = 1'b0;
        o_sel   = '0;
        w_idx   = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_idx = (int'(i_rr_ptr) + i) % NUM_CORES;
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_sel   = IW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ws_mem_scheduler
// Purpose  : Shares one weight/psum memory port between NUM_CORES
//            weight-stationary cores. Round-robin arbitration picks one core
//            per transaction; each transaction is a fixed-length burst
//            (load = memory read, unload = memory write) with a valid/ready
//            beat handshake and addresses taken from a per-core base table.
// Ports    : clk, reset (async, active-high)
//            req/req_unload        - per-core request and op select
//            grant/done            - one-hot grant, one-cycle done pulse
//            busy                  - scheduler not idle
//            mem_valid/mem_ready   - beat handshake
//            mem_rw/mem_addr       - beat direction and address
//            beat_idx              - beat number within the burst
//            cfg_we/cfg_core/cfg_base - base-address table write port
// Options  : WS_SCHED_PERF_EN adds perf_stall and perf_xfers counters.
// Revision : 1.0 - initial release
// ============================================================================
module ws_mem_scheduler
    import ws_sched_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int AW           = 6,
    parameter int LOAD_BURST   = 16,
    parameter int UNLOAD_BURST = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CORES-1:0]         req,
    input  logic [NUM_CORES-1:0]         req_unload,
    output logic [NUM_CORES-1:0]         grant,
    output logic [NUM_CORES-1:0]         done,
    output logic                         busy,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic                         mem_rw,
    output logic [AW-1:0]                mem_addr,
    output logic [BEAT_W-1:0]            beat_idx,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CORES)-1:0] cfg_core,
    input  logic [AW-1:0]                cfg_base
`ifdef WS_SCHED_PERF_EN
    ,
    output logic [15:0]                  perf_stall,
    output logic [15:0]                  perf_xfers
`endif
);

    localparam int IW = $clog2(NUM_CORES);

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_CORES-1:0]  r_grant;
    logic [IW-1:0]         r_rr_ptr;
    op_t                   r_op;
    logic                  r_mem_rw;
    logic [AW-1:0]         r_base;
    logic [AW-1:0]         r_base_tbl [NUM_CORES];
    logic [BEAT_W-1:0]     r_beat;
    logic [BEAT_W-1:0]     r_len;

    logic                  w_pick_valid;
    logic [IW-1:0]         w_pick_sel;
    logic                  w_last_beat;
    logic                  w_cfg_ok;
    logic                  w_mem_valid;
    logic [NUM_CORES-1:0]  w_done;
    logic                  w_busy;

    ws_rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IW        (IW)
    ) u_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_sel    (w_pick_sel)
    );

    assign w_last_beat = (r_beat == (r_len - BEAT_W'(1)));
    // Non-power-of-two core counts leave table indices with no entry.
    assign w_cfg_ok    = (32'(cfg_core) < 32'(NUM_CORES));

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        w_next_state = r_state;
        w_mem_valid  = 1'b0;
        w_done       = '0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_pick_valid) begin
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                w_next_state = XFER;
            end
            XFER: begin
                w_mem_valid = 1'b1;
                if (mem_ready && w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_done       = r_grant;
                w_next_state = IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    // ---------------- Transaction datapath ----------------
    // Op and base are captured at arbitration time, so later req_unload or
    // table writes cannot disturb an in-flight burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_op     <= OP_LOAD;
            r_mem_rw <= 1'b0;
            r_base   <= '0;
            r_beat   <= '0;
            r_len    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant  <= {{(NUM_CORES-1){1'b0}}, 1'b1} << w_pick_sel;
                        r_op     <= op_t'(req_unload[w_pick_sel]);
                        r_base   <= r_base_tbl[w_pick_sel];
                        r_beat   <= '0;
                        r_rr_ptr <= (w_pick_sel == IW'(NUM_CORES - 1)) ?
                                    '0 : (w_pick_sel + IW'(1));
                    end
                end
                GRANT: begin
                    r_mem_rw <= (r_op == OP_UNLOAD);
                    r_len    <= (r_op == OP_UNLOAD) ? BEAT_W'(UNLOAD_BURST)
                                                    : BEAT_W'(LOAD_BURST);
                end
                XFER: begin
                    if (mem_ready) begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Base-address table ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_base_tbl[i] <= '0;
            end
        end else if (cfg_we && w_cfg_ok) begin
            r_base_tbl[cfg_core] <= cfg_base;
        end
    end

    assign grant     = r_grant;
    assign done      = w_done;
    assign busy      = w_busy;
    assign mem_valid = w_mem_valid;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_base + AW'(r_beat);
    assign beat_idx  = r_beat;

`ifdef WS_SCHED_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_xfers;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_xfers <= '0;
        end else begin
            if (w_mem_valid && !mem_ready && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
            if ((r_state == DONE) && (r_perf_xfers != 16'hFFFF)) begin
                r_perf_xfers <= r_perf_xfers + 16'd1;
            end
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_xfers = r_perf_xfers;
`endif

endmodule
`default_nettype wire
